// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared sign-magnitude Q7.8 constants and FSM states
package fxp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fxp_state_t;

  localparam int FRAC_BITS = 8;
  localparam int MAG_BITS  = 15;
  localparam int SIGN_BIT  = 15;
  localparam int ACC_W     = 30;

endpackage

// File: rtl/fxp_mul_unit.sv
// rtl/fxp_mul_unit.sv - sequential shift-add sign-magnitude Q7.8 multiplier
module fxp_mul_unit
  import fxp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c,
  output logic         cout,
  output logic         zero,
  output logic         overflow,
  output logic         neg
);

  localparam int P_W = ACC_W - FRAC_BITS;

  fxp_state_t state, state_next;

  logic [15:0]         op_a, op_b;
  logic [ACC_W-1:0]    acc, acc_next, addend;
  logic [3:0]          count;
  logic [P_W-1:0]      p_next;
  logic                ovf_next, sign_next;
  logic [MAG_BITS-1:0] mag_next;
  logic [15:0]         c_r;
  logic                start_accept, last_step;
  logic                unused_hi;

  assign unused_hi = &{1'b0, a[N-1:16], b[N-1:16]};

  assign start_accept = start && (state != BUSY);
  assign last_step    = (state == BUSY) && (count == 4'd14);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (start) state_next = BUSY;
      default: state_next = IDLE;
    endcase
  end

  // One multiplier bit per cycle; the final step's sum feeds the result directly.
  always_comb begin
    addend   = ACC_W'(op_a[MAG_BITS-1:0]) << count;
    acc_next = acc;
    if (op_b[count]) acc_next = acc + addend;
    p_next    = acc_next[ACC_W-1:FRAC_BITS];
    ovf_next  = |p_next[P_W-1:MAG_BITS];
    mag_next  = ovf_next ? {MAG_BITS{1'b1}} : p_next[MAG_BITS-1:0];
    sign_next = (op_a[SIGN_BIT] ^ op_b[SIGN_BIT]) & (|mag_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      count    <= '0;
      done     <= 1'b0;
      c_r      <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_accept) begin
        op_a     <= a[15:0];
        op_b     <= b[15:0];
        acc      <= '0;
        count    <= '0;
        c_r      <= '0;
        cout     <= 1'b0;
        zero     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == BUSY) begin
        acc   <= acc_next;
        count <= count + 4'd1;
        if (last_step) begin
          done     <= 1'b1;
          c_r      <= {sign_next, mag_next};
          cout     <= p_next[MAG_BITS];
          zero     <= ~|mag_next;
          overflow <= ovf_next;
        end
      end
    end
  end

  assign busy = (state == BUSY);
  assign c    = N'(c_r);
  assign neg  = c_r[SIGN_BIT];

endmodule

// File: tb/tb_fxp_mul_unit.sv
// tb/tb_fxp_mul_unit.sv - self-checking bench for fxp_mul_unit
module tb_fxp_mul_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, zero, overflow, neg;
  logic [N-1:0] c;

  int n_cmp = 0;
  int n_bad = 0;

  fxp_mul_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .c(c), .cout(cout),
    .zero(zero), .overflow(overflow), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: timer since accept plus integer product arithmetic.
  bit          started = 0;
  bit          m_busy = 0, m_done = 0;
  int          m_cnt = 0;
  longint      m_ma, m_mb;
  bit          m_sgn;
  logic [31:0] m_c = 0;
  bit          m_cout = 0, m_zero = 0, m_ovf = 0;

  always @(posedge clk) begin
    longint prod, p, mag;
    bit ovf;
    started = 1;
    if (rst) begin
      m_busy = 0; m_done = 0; m_c = 0; m_cout = 0; m_zero = 0; m_ovf = 0;
    end else if (start && !m_busy) begin
      m_ma  = longint'(a[14:0]);
      m_mb  = longint'(b[14:0]);
      m_sgn = a[15] ^ b[15];
      m_cnt = 0; m_busy = 1; m_done = 0;
      m_c = 0; m_cout = 0; m_zero = 0; m_ovf = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 15) begin
        prod   = m_ma * m_mb;
        p      = prod / 256;
        ovf    = (p >= 32768);
        mag    = ovf ? 32767 : (p % 32768);
        m_ovf  = ovf;
        m_cout = ((p / 32768) % 2) == 1;
        m_zero = (mag == 0);
        m_c    = 32'(mag) + ((m_sgn && mag != 0) ? 32'h8000 : 32'h0);
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("c", c, m_c);
      chk("cout", 32'(cout), 32'(m_cout));
      chk("zero", 32'(zero), 32'(m_zero));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("neg", 32'(neg), 32'(m_c[15]));
    end
  end

  task automatic do_start(input logic [31:0] va, input logic [31:0] vb);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_res(input string name, input logic [31:0] ec, input bit ecout,
                         input bit ezero, input bit eovf, input bit eneg);
    chk({name, ".c"}, c, ec);
    chk({name, ".cout"}, 32'(cout), 32'(ecout));
    chk({name, ".zero"}, 32'(zero), 32'(ezero));
    chk({name, ".ovf"}, 32'(overflow), 32'(eovf));
    chk({name, ".neg"}, 32'(neg), 32'(eneg));
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ec, input bit ecout, input bit ezero,
                        input bit eovf, input bit eneg);
    int lat;
    do_start(va, vb);
    wait_done(lat);
    chk({name, ".lat"}, 32'(lat), 32'd15);
    chk_res(name, ec, ecout, ezero, eovf, eneg);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst.c", c, 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("one", 32'h0100, 32'h0100, 32'h00000100, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("hold.c", c, 32'h00000100);
    chk("hold.done", 32'(done), 32'h0);
    run_op("neg", 32'h8280, 32'h0180, 32'h000083C0, 0, 0, 0, 1);
    run_op("max", 32'h7FFF, 32'h7FFF, 32'h00007FFF, 1, 0, 1, 0);
    run_op("zeroneg", 32'h8000, 32'h0123, 32'h0, 0, 1, 0, 0);
    run_op("hibits", 32'hABCD0100, 32'hFFFF0100, 32'h00000100, 0, 0, 0, 0);
    run_op("edge_nov", 32'h0100, 32'h7FFF, 32'h00007FFF, 0, 0, 0, 0);
    run_op("edge_ovf", 32'h8200, 32'h4000, 32'h0000FFFF, 1, 0, 1, 1);
    run_op("trunc", 32'h8001, 32'h0001, 32'h0, 0, 1, 0, 0);

    do_start(32'h0300, 32'h0400);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.c", c, 32'h0);
    chk("abort.done", 32'(done), 32'h0);
    repeat (12) @(negedge clk);
    run_op("after_rst", 32'h0200, 32'h0300, 32'h00000600, 0, 0, 0, 0);

    do_start(32'h0280, 32'h0180);
    repeat (2) @(negedge clk);
    a = 32'h7FFF; b = 32'h7FFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign.lat", 32'(lat), 32'd12);
    chk_res("ign", 32'h000003C0, 0, 0, 0, 0);
    do_start(32'h0400, 32'h8080);
    chk("b2b.busy", 32'(busy), 32'h1);
    wait_done(lat);
    chk("b2b.lat", 32'(lat), 32'd15);
    chk_res("b2b", 32'h00008200, 0, 0, 0, 1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
